// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the pc, reads a combinational instruction
// memory, and hands one registered word per cycle to decode under a
// valid/ready handshake. Redirects flush the output register; misaligned or
// out-of-range fetch addresses latch a sticky fault that only reset clears.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_instruction,
  output logic [31:0] out_pc,
  output logic        fault,
  output logic [15:0] fetch_count
);

  localparam logic [31:0] LastAddr = 32'(MEM_BYTES - 4);

  typedef enum logic [1:0] {
    StStart = 2'd0,
    StRun   = 2'd1,
    StFault = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instruction_q, out_instruction_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        fault_q, fault_d;
  logic [15:0] fetch_count_q, fetch_count_d;

  logic transfer;
  logic capture_en;

  // A word address is usable only if aligned and inside the memory.
  function automatic logic bad_addr(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr > LastAddr);
  endfunction

  assign transfer   = out_valid_q & out_ready;
  assign capture_en = ~out_valid_q | out_ready;

  // Next-state logic: redirect beats capture/stall; faults freeze the pc.
  always_comb begin
    state_d           = state_q;
    pc_d              = pc_q;
    out_valid_d       = out_valid_q;
    out_instruction_d = out_instruction_q;
    out_pc_d          = out_pc_q;
    fault_d           = fault_q;
    fetch_count_d     = fetch_count_q;

    // A handshake counts even if the same cycle redirects or faults.
    if (transfer && (fetch_count_q != 16'hFFFF)) begin
      fetch_count_d = fetch_count_q + 16'd1;
    end

    unique case (state_q)
      StStart: begin
        // Settle cycle after reset: memory output is not trusted yet.
        out_valid_d = 1'b0;
        if (redirect_valid) begin
          if (bad_addr(redirect_target)) begin
            state_d = StFault;
            fault_d = 1'b1;
          end else begin
            pc_d    = redirect_target;
            state_d = StRun;
          end
        end else if (bad_addr(pc_q)) begin
          state_d = StFault;
          fault_d = 1'b1;
        end else begin
          state_d = StRun;
        end
      end

      StRun: begin
        if (redirect_valid) begin
          out_valid_d = 1'b0;
          if (bad_addr(redirect_target)) begin
            state_d = StFault;
            fault_d = 1'b1;
          end else begin
            pc_d = redirect_target;
          end
        end else if (capture_en) begin
          if (bad_addr(pc_q)) begin
            // Sequential fetch ran off the end: do not capture this word.
            out_valid_d = 1'b0;
            state_d     = StFault;
            fault_d     = 1'b1;
          end else begin
            out_instruction_d = imem_instruction;
            out_pc_d          = pc_q;
            out_valid_d       = 1'b1;
            pc_d              = pc_q + 32'd4;
          end
        end
        // Otherwise stalled: everything holds.
      end

      StFault: begin
        out_valid_d = 1'b0;
        fault_d     = 1'b1;
      end

      default: begin
        out_valid_d = 1'b0;
        state_d     = StFault;
        fault_d     = 1'b1;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= StStart;
      pc_q              <= RESET_PC;
      out_valid_q       <= 1'b0;
      out_instruction_q <= 32'd0;
      out_pc_q          <= 32'd0;
      fault_q           <= 1'b0;
      fetch_count_q     <= 16'd0;
    end else begin
      state_q           <= state_d;
      pc_q              <= pc_d;
      out_valid_q       <= out_valid_d;
      out_instruction_q <= out_instruction_d;
      out_pc_q          <= out_pc_d;
      fault_q           <= fault_d;
      fetch_count_q     <= fetch_count_d;
    end
  end

  assign imem_address    = pc_q;
  assign out_valid       = out_valid_q;
  assign out_instruction = out_instruction_q;
  assign out_pc          = out_pc_q;
  assign fault           = fault_q;
  assign fetch_count     = fetch_count_q;

endmodule
